// File: rtl/cu_fsm.sv
// cu_fsm - multicycle control unit for the OTTER RV32I core.
//
// Sequences each instruction through FETCH, EXEC and (for loads) WB, with an
// optional interrupt-entry cycle (INTR) after the last cycle of an instruction.
// Outputs are Moore-style from the state, except in EXEC where they are also
// decoded from the opcode/func3 of the instruction register.
//
// Configuration macro: CU_INTR_EN
//   defined   - INTR state exists, CU_intr honored, mret/CSR decode active
//   undefined - interrupt logic removed, SYSTEM opcodes execute as NOPs
//
// Ports:
//   CU_clk        in   system clock, rising edge
//   CU_rst        in   synchronous active-high reset
//   CU_opcode     in   [6:0] instruction opcode
//   CU_func3      in   [2:0] instruction func3
//   CU_intr       in   level interrupt request (already enable-gated)
//   CU_PCWrite    out  PC write enable (once per instruction, last cycle)
//   CU_reset      out  reset to PC and register file
//   CU_memRDEN1   out  instruction-port read enable
//   CU_memRDEN2   out  data-port read enable
//   CU_memWE2     out  data-port write enable
//   CU_regWrite   out  register-file write enable
//   CU_csr_WE     out  CSR write enable
//   CU_int_taken  out  interrupt entry pulse
//   CU_mret_exec  out  mret execution pulse

module cu_fsm (
    input  logic       CU_clk,
    input  logic       CU_rst,
    input  logic [6:0] CU_opcode,
    input  logic [2:0] CU_func3,
    input  logic       CU_intr,
    output logic       CU_PCWrite,
    output logic       CU_reset,
    output logic       CU_memRDEN1,
    output logic       CU_memRDEN2,
    output logic       CU_memWE2,
    output logic       CU_regWrite,
    output logic       CU_csr_WE,
    output logic       CU_int_taken,
    output logic       CU_mret_exec
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
`ifdef CU_INTR_EN
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
`else
        ST_WB    = 3'd3
`endif
    } state_t;

    state_t state;
    state_t next_state;
    state_t after_instr;

    // Where to go once the current instruction retires: interrupt entry when
    // requested, otherwise straight to the next fetch.
`ifdef CU_INTR_EN
    assign after_instr = CU_intr ? ST_INTR : ST_FETCH;
`else
    assign after_instr = ST_FETCH;
    logic unused_inputs;
    assign unused_inputs = ^{CU_intr, CU_func3};
`endif

    // State register; reset wins over everything else at the edge.
    always_ff @(posedge CU_clk) begin
        if (CU_rst) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state   = ST_INIT;
        CU_PCWrite   = 1'b0;
        CU_reset     = 1'b0;
        CU_memRDEN1  = 1'b0;
        CU_memRDEN2  = 1'b0;
        CU_memWE2    = 1'b0;
        CU_regWrite  = 1'b0;
        CU_csr_WE    = 1'b0;
        CU_int_taken = 1'b0;
        CU_mret_exec = 1'b0;

        case (state)
            ST_INIT: begin
                CU_reset   = 1'b1;
                next_state = ST_FETCH;
            end

            ST_FETCH: begin
                CU_memRDEN1 = 1'b1;
                next_state  = ST_EXEC;
            end

            ST_EXEC: begin
                next_state = after_instr;
                case (CU_opcode)
                    // Loads retire in WB, so PC and interrupts wait until then.
                    OP_LOAD: begin
                        CU_memRDEN2 = 1'b1;
                        next_state  = ST_WB;
                    end
                    OP_STORE: begin
                        CU_memWE2  = 1'b1;
                        CU_PCWrite = 1'b1;
                    end
                    OP_BRANCH: begin
                        CU_PCWrite = 1'b1;
                    end
                    OP_LUI, OP_AUIPC, OP_IMM, OP_OP, OP_JAL, OP_JALR: begin
                        CU_regWrite = 1'b1;
                        CU_PCWrite  = 1'b1;
                    end
`ifdef CU_INTR_EN
                    OP_SYSTEM: begin
                        CU_PCWrite = 1'b1;
                        if (CU_func3 == 3'b000) begin
                            CU_mret_exec = 1'b1;
                        end else begin
                            CU_regWrite = 1'b1;
                            CU_csr_WE   = 1'b1;
                        end
                    end
`endif
                    default: begin
                        CU_PCWrite = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                CU_regWrite = 1'b1;
                CU_PCWrite  = 1'b1;
                next_state  = after_instr;
            end

`ifdef CU_INTR_EN
            // Always fetch after entry, so interrupts cannot chain back to back.
            ST_INTR: begin
                CU_int_taken = 1'b1;
                CU_PCWrite   = 1'b1;
                next_state   = ST_FETCH;
            end
`endif

            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// tb_cu_fsm - randomized scoreboard bench for cu_fsm.
//
// The stimulus process walks instruction by instruction, computing from the
// instruction-level rules which control strobes each cycle should show, and
// queues them. A monitor on the falling edge pops one expectation per cycle
// and compares it with the DUT outputs.

module tb_cu_fsm;

    logic       CU_clk = 1'b0;
    logic       CU_rst;
    logic [6:0] CU_opcode;
    logic [2:0] CU_func3;
    logic       CU_intr;
    logic       CU_PCWrite;
    logic       CU_reset;
    logic       CU_memRDEN1;
    logic       CU_memRDEN2;
    logic       CU_memWE2;
    logic       CU_regWrite;
    logic       CU_csr_WE;
    logic       CU_int_taken;
    logic       CU_mret_exec;

    cu_fsm dut (
        .CU_clk       (CU_clk),
        .CU_rst       (CU_rst),
        .CU_opcode    (CU_opcode),
        .CU_func3     (CU_func3),
        .CU_intr      (CU_intr),
        .CU_PCWrite   (CU_PCWrite),
        .CU_reset     (CU_reset),
        .CU_memRDEN1  (CU_memRDEN1),
        .CU_memRDEN2  (CU_memRDEN2),
        .CU_memWE2    (CU_memWE2),
        .CU_regWrite  (CU_regWrite),
        .CU_csr_WE    (CU_csr_WE),
        .CU_int_taken (CU_int_taken),
        .CU_mret_exec (CU_mret_exec)
    );

    always #5 CU_clk = ~CU_clk;

`ifdef CU_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    // Bit positions of each strobe in an expectation vector.
    localparam int B_PCW  = 8;
    localparam int B_RST  = 7;
    localparam int B_RD1  = 6;
    localparam int B_RD2  = 5;
    localparam int B_WE2  = 4;
    localparam int B_REG  = 3;
    localparam int B_CSR  = 2;
    localparam int B_INT  = 1;
    localparam int B_MRET = 0;

    typedef logic [8:0] vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    fails  = 0;
    bit    stim_done = 1'b0;

    function automatic vec_t bitv(input int b);
        vec_t v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // What an instruction does in its execute cycle, by RV32I opcode class.
    function automatic vec_t exec_vec(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return bitv(B_RD2);
            7'b0100011: return bitv(B_WE2) | bitv(B_PCW);
            7'b1100011: return bitv(B_PCW);
            7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011,
            7'b1101111, 7'b1100111: return bitv(B_REG) | bitv(B_PCW);
            7'b1110011: begin
                if (!INTR_EN) return bitv(B_PCW);
                if (f3 == 3'b000) return bitv(B_MRET) | bitv(B_PCW);
                return bitv(B_REG) | bitv(B_CSR) | bitv(B_PCW);
            end
            default: return bitv(B_PCW);
        endcase
    endfunction

    function automatic logic pick_intr(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    task automatic tick();
        @(posedge CU_clk);
        #1;
    endtask

    // Queue the expectation for the current cycle, then let the cycle run.
    task automatic expect_cycle(input vec_t v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        tick();
    endtask

    // Reset held for 'hold' further edges, then one release cycle still in INIT.
    task automatic do_reset(input int hold);
        for (int i = 0; i < hold; i++) begin
            CU_rst = 1'b1;
            expect_cycle(bitv(B_RST), "reset_hold");
        end
        CU_rst = 1'b0;
        expect_cycle(bitv(B_RST), "reset_release");
    endtask

    // One instruction. imode: 0 intr low, 1 intr high, 2 random per cycle.
    // rst_at: cycle index (0 = fetch) at which reset is asserted, -1 for none.
    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                  input int imode, input int rst_at);
        logic take_intr;
        bit   is_load;
        int   k;
        is_load   = (op == 7'b0000011);
        CU_opcode = op;
        CU_func3  = f3;
        k = 0;

        CU_intr = pick_intr(imode);
        CU_rst  = (rst_at == k);
        expect_cycle(bitv(B_RD1), $sformatf("fetch op=%b", op));
        if (rst_at == k) begin do_reset($urandom_range(0, 2)); return; end
        k++;

        CU_intr   = pick_intr(imode);
        take_intr = CU_intr;
        CU_rst    = (rst_at == k);
        expect_cycle(exec_vec(op, f3), $sformatf("exec op=%b f3=%b", op, f3));
        if (rst_at == k) begin do_reset($urandom_range(0, 2)); return; end
        k++;

        if (is_load) begin
            CU_intr   = pick_intr(imode);
            take_intr = CU_intr;
            CU_rst    = (rst_at == k);
            expect_cycle(bitv(B_REG) | bitv(B_PCW), "load_wb");
            if (rst_at == k) begin do_reset($urandom_range(0, 2)); return; end
            k++;
        end

        if (INTR_EN && take_intr) begin
            CU_intr = pick_intr(imode);
            CU_rst  = (rst_at == k);
            expect_cycle(bitv(B_INT) | bitv(B_PCW), "intr_entry");
            if (rst_at == k) begin do_reset($urandom_range(0, 2)); return; end
        end
        CU_rst = 1'b0;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    task automatic check_output();
        vec_t  e;
        vec_t  a;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {CU_PCWrite, CU_reset, CU_memRDEN1, CU_memRDEN2, CU_memWE2,
             CU_regWrite, CU_csr_WE, CU_int_taken, CU_mret_exec};
        checks++;
        if (a !== e) begin
            fails++;
            $display("[TB] FAIL %s: outputs %b, required %b (PCW,RST,RD1,RD2,WE2,REG,CSR,INT,MRET)",
                     t, a, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge CU_clk);
            if (exp_q.size() > 0) check_output();
        end
    end

    logic [6:0] op_list[11] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                                7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111,
                                7'b1100111, 7'b1110011, 7'b1110011};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        CU_rst    = 1'b1;
        CU_intr   = 1'b0;
        CU_opcode = 7'b0110011;
        CU_func3  = 3'b000;
        // First edge gives a known state; no expectation before it.
        tick();
        do_reset(2);

        // Directed scenarios.
        apply_stimulus(7'b0110011, 3'b000, 0, -1);
        apply_stimulus(7'b0000011, 3'b010, 1, -1);
        apply_stimulus(7'b0100011, 3'b010, 1, -1);
        apply_stimulus(7'b1110011, 3'b000, 0, -1);
        apply_stimulus(7'b1110011, 3'b001, 0, -1);
        apply_stimulus(7'b0000011, 3'b010, 0, 2);
        apply_stimulus(7'b1110011, 3'b010, 1, -1);
        apply_stimulus(7'b1111111, 3'b000, 1, -1);

        // Randomized instruction stream with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) op = 7'($urandom);
            else op = op_list[$urandom_range(0, 10)];
            f3 = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
            apply_stimulus(op, f3, 2,
                           ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        stim_done = 1'b1;
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
